// File: rtl/bch_syndrome_calculator.sv
// Serial BCH syndrome engine over GF(2^m).
// It consumes one received bit per handshake, highest-degree coefficient first,
// and evaluates S_j = r(alpha^j) for j = 1..2*T_P using Horner's rule.
// The field degree m and the codeword length n are latched on the first beat of
// each frame. The 2*T_P results are presented together, one cycle after in_last.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   cfg_m, cfg_n      field degree and codeword length, sampled on the first beat
//   in_valid/in_ready/in_data/in_last   input bit stream
//   out_valid/out_ready                 result handshake
//   out_syndromes     S_1 occupies the LSBs, with MAX_M_P bits per syndrome
//   out_nonzero       an error is detected
//   out_len_err       the beat count differs from cfg_n
//   out_cfg_err       cfg_m is outside 5..MAX_M_P
module bch_syndrome_calculator #(
  parameter int MAX_M_P   = 15,
  parameter int T_P       = 4,
  parameter int N_WIDTH_P = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 cfg_m,
  input  logic [N_WIDTH_P-1:0]       cfg_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*T_P*MAX_M_P-1:0]   out_syndromes,
  output logic                       out_nonzero,
  output logic                       out_len_err,
  output logic                       out_cfg_err
);

  localparam int NS = 2 * T_P;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                 state;
  logic [3:0]             m_q;
  logic [N_WIDTH_P-1:0]   n_q;
  logic [N_WIDTH_P-1:0]   count;
  logic                   ovf;
  logic [MAX_M_P-1:0]     acc      [NS];
  logic [MAX_M_P-1:0]     acc_next [NS];

  logic                   beat;
  logic [3:0]             m_sel;
  logic [N_WIDTH_P-1:0]   n_sel;
  logic                   cfg_err_sel;
  logic [15:0]            poly_sel;
  logic [15:0]            mask_sel;
  logic [15:0]            top_sel;
  logic [15:0]            x;
  logic [N_WIDTH_P-1:0]   count_next;
  logic                   ovf_next;
  logic                   any_nonzero;
  logic                   len_err_next;

  function automatic logic [15:0] poly_for(input logic [3:0] m);
    case (m)
      4'd5:    poly_for = 16'h0025;
      4'd6:    poly_for = 16'h0043;
      4'd7:    poly_for = 16'h0083;
      4'd8:    poly_for = 16'h011D;
      4'd9:    poly_for = 16'h0211;
      4'd10:   poly_for = 16'h0409;
      4'd11:   poly_for = 16'h0805;
      4'd12:   poly_for = 16'h1053;
      4'd13:   poly_for = 16'h201B;
      4'd14:   poly_for = 16'h402B;
      4'd15:   poly_for = 16'h8003;
      default: poly_for = 16'h0000;
    endcase
  endfunction

  // Multiply by alpha: shift, reduce by the polynomial when bit m is set, then mask to m bits.
  function automatic logic [15:0] mul_alpha(input logic [15:0] v, input logic [15:0] poly,
                                            input logic [15:0] mask, input logic [15:0] top);
    logic [15:0] t;
    t = v << 1;
    if ((t & top) != 16'd0) t = t ^ poly;
    return t & mask;
  endfunction

  // In IDLE, the first beat uses the live configuration. Afterwards, the latched copy is used,
  // so configuration changes in the middle of a frame are ignored.
  always_comb begin
    beat        = in_valid && in_ready;
    m_sel       = (state == IDLE) ? cfg_m : m_q;
    n_sel       = (state == IDLE) ? cfg_n : n_q;
    cfg_err_sel = (m_sel < 4'd5) || (m_sel > 4'(MAX_M_P));
    poly_sel    = poly_for(m_sel);
    top_sel     = 16'd1 << m_sel;
    mask_sel    = top_sel - 16'd1;
    any_nonzero = 1'b0;
    x           = '0;
    for (int j = 0; j < NS; j++) begin
      x = '0;
      x[MAX_M_P-1:0] = acc[j];
      // S_(j+1) uses j+1 chained multiply-by-alpha stages.
      for (int k = 0; k < NS; k++) begin
        if (k <= j) x = mul_alpha(x, poly_sel, mask_sel, top_sel);
      end
      x = x ^ {15'd0, in_data};
      acc_next[j] = cfg_err_sel ? acc[j] : x[MAX_M_P-1:0];
      any_nonzero = any_nonzero | (|acc_next[j]);
    end
    // The counter saturates. The sticky overflow bit keeps an over-long frame from matching cfg_n.
    if (state == IDLE) begin
      count_next = {{(N_WIDTH_P-1){1'b0}}, 1'b1};
      ovf_next   = 1'b0;
    end else if (count == '1) begin
      count_next = count;
      ovf_next   = 1'b1;
    end else begin
      count_next = count + 1'b1;
      ovf_next   = ovf;
    end
    len_err_next = ovf_next || (count_next != n_sel);
  end

  always_comb begin
    out_syndromes = '0;
    for (int j = 0; j < NS; j++) out_syndromes[j*MAX_M_P +: MAX_M_P] = acc[j];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      m_q         <= '0;
      n_q         <= '0;
      count       <= '0;
      ovf         <= 1'b0;
      acc         <= '{default: '0};
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_nonzero <= 1'b0;
      out_len_err <= 1'b0;
      out_cfg_err <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (beat) begin
            if (state == IDLE) begin
              m_q <= cfg_m;
              n_q <= cfg_n;
            end
            acc   <= acc_next;
            count <= count_next;
            ovf   <= ovf_next;
            if (in_last) begin
              state       <= DONE;
              in_ready    <= 1'b0;
              out_valid   <= 1'b1;
              out_nonzero <= any_nonzero && !cfg_err_sel;
              out_len_err <= len_err_next;
              out_cfg_err <= cfg_err_sel;
            end else begin
              state <= ACCUM;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            acc         <= '{default: '0};
            count       <= '0;
            ovf         <= 1'b0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_nonzero <= 1'b0;
            out_len_err <= 1'b0;
            out_cfg_err <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bch_syndrome_calculator.sv
module tb_bch_syndrome_calculator;
  localparam int M  = 15;
  localparam int T  = 4;
  localparam int NW = 16;
  localparam int NS = 2 * T;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        cfg_m;
  logic [NW-1:0]     cfg_n;
  logic              in_valid, in_ready, in_data, in_last;
  logic              out_valid, out_ready;
  logic [NS*M-1:0]   out_syndromes;
  logic              out_nonzero, out_len_err, out_cfg_err;

  bch_syndrome_calculator #(.MAX_M_P(M), .T_P(T), .N_WIDTH_P(NW)) dut (
    .clk(clk), .rst(rst), .cfg_m(cfg_m), .cfg_n(cfg_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_syndromes(out_syndromes),
    .out_nonzero(out_nonzero), .out_len_err(out_len_err), .out_cfg_err(out_cfg_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [NS*M-1:0] exp_syn;
  logic            exp_nz, exp_len, exp_cfg;
  logic            exp_pending = 1'b0;
  bit              frame_bits [1024];
  bit              saved_bits [1024];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int poly_of(input int m);
    case (m)
      5: return 'h25;     6: return 'h43;     7: return 'h83;     8: return 'h11D;
      9: return 'h211;    10: return 'h409;   11: return 'h805;   12: return 'h1053;
      13: return 'h201B;  14: return 'h402B;  15: return 'h8003;
      default: return 0;
    endcase
  endfunction

  // alpha^e evaluated as the polynomial x^e reduced modulo the field polynomial.
  function automatic int alpha_pow(input int m, input int e);
    int v = 1;
    int ee = e % ((1 << m) - 1);
    for (int i = 0; i < ee; i++) begin
      v = v << 1;
      if ((v >> m) & 1) v = v ^ poly_of(m);
    end
    return v;
  endfunction

  // Model: S_j is the XOR, over every set coefficient r_d, of alpha^(d*j).
  task automatic compute_model(input int m, input int n, input int nbeats);
    int s;
    exp_cfg = (m < 5) || (m > M);
    exp_syn = '0;
    if (!exp_cfg) begin
      for (int b = 0; b < nbeats; b++) begin
        if (frame_bits[b]) begin
          for (int j = 1; j <= NS; j++) begin
            s = alpha_pow(m, (nbeats - 1 - b) * j);
            exp_syn[(j-1)*M +: M] = exp_syn[(j-1)*M +: M] ^ s[M-1:0];
          end
        end
      end
    end
    exp_nz  = (exp_syn != '0);
    exp_len = (nbeats != n);
  endtask

  function automatic logic [M-1:0] syn_at(input int j);
    return out_syndromes[(j-1)*M +: M];
  endfunction

  task automatic clear_bits();
    for (int i = 0; i < 1024; i++) frame_bits[i] = 1'b0;
  endtask

  // Sends one frame. If abort is 0 or more, sending stops before beat 'abort' and no result is expected.
  task automatic send_frame(input int m, input int n, input int nbeats, input bit gaps, input int abort);
    if (abort < 0) begin
      compute_model(m, n, nbeats);
      exp_pending = 1'b1;
    end
    chk("ready_at_start", in_ready, 1'b1);
    for (int b = 0; b < nbeats; b++) begin
      if (b == abort) begin
        in_valid = 1'b0;
        return;
      end
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      if (b == 0) begin
        cfg_m = 4'(m);
        cfg_n = 16'(n);
      end else begin
        cfg_m = 4'($urandom);
        cfg_n = 16'($urandom);
      end
      in_valid = 1'b1;
      in_data  = frame_bits[b];
      in_last  = (b == nbeats - 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("latency_valid", out_valid, 1'b1);
  endtask

  task automatic finish_frame(input int hold);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_in_ready", in_ready, 1'b0);
      chk("hold_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready   = 1'b0;
    exp_pending = 1'b0;
    chk("valid_cleared", out_valid, 1'b0);
    chk("ready_back", in_ready, 1'b1);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (!exp_pending) begin
        chk("spurious_valid", out_valid, 1'b0);
      end else begin
        chk("syndromes", out_syndromes, exp_syn);
        chk("nonzero", out_nonzero, exp_nz);
        chk("len_err", out_len_err, exp_len);
        chk("cfg_err", out_cfg_err, exp_cfg);
        chk("in_ready_low", in_ready, 1'b0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NS*M-1:0] gapless_syn;
    rst = 1'b1; cfg_m = 4'd5; cfg_n = 16'd31; in_valid = 1'b0; in_data = 1'b0;
    in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_syndromes", out_syndromes, '0);
    chk("rst_flags", {out_nonzero, out_len_err, out_cfg_err}, 3'b000);

    // m=5, all zero
    clear_bits();
    send_frame(5, 31, 31, 1'b0, -1);
    chk("zero_s1", syn_at(1), 15'h0);
    chk("zero_nz", out_nonzero, 1'b0);
    finish_frame(0);

    // m=5, only r_1 set
    clear_bits(); frame_bits[29] = 1'b1;
    send_frame(5, 31, 31, 1'b0, -1);
    chk("r1_s1", syn_at(1), 15'h02);
    chk("r1_s2", syn_at(2), 15'h04);
    chk("r1_s3", syn_at(3), 15'h08);
    chk("r1_s4", syn_at(4), 15'h10);
    chk("r1_s5", syn_at(5), 15'h05);
    chk("r1_s6", syn_at(6), 15'h0A);
    chk("r1_s7", syn_at(7), 15'h14);
    chk("r1_s8", syn_at(8), 15'h0D);
    chk("r1_nz", out_nonzero, 1'b1);
    finish_frame(1);

    // m=5, only r_0 set
    clear_bits(); frame_bits[30] = 1'b1;
    send_frame(5, 31, 31, 1'b0, -1);
    for (int j = 1; j <= NS; j++) chk("r0_sj", syn_at(j), 15'h01);
    finish_frame(0);

    // m=8, only r_1 set. A second pass holds out_ready low.
    clear_bits(); frame_bits[253] = 1'b1;
    send_frame(8, 255, 255, 1'b0, -1);
    chk("m8_s1", syn_at(1), 15'h02);
    chk("m8_s8", syn_at(8), 15'h1D);
    finish_frame(0);
    send_frame(8, 255, 255, 1'b0, -1);
    finish_frame(10);

    // Short frame triggers the length error.
    clear_bits(); frame_bits[3] = 1'b1;
    send_frame(5, 31, 20, 1'b0, -1);
    chk("short_len_err", out_len_err, 1'b1);
    finish_frame(0);

    // An illegal m consumes the frame but yields zero syndromes.
    for (int i = 0; i < 31; i++) frame_bits[i] = 1'($urandom);
    frame_bits[0] = 1'b1;
    send_frame(4, 31, 31, 1'b0, -1);
    chk("bad_m_cfg_err", out_cfg_err, 1'b1);
    chk("bad_m_syn", out_syndromes, '0);
    finish_frame(0);

    // Random frames in larger fields
    for (int i = 0; i < 127; i++) frame_bits[i] = 1'($urandom);
    send_frame(7, 127, 127, 1'b0, -1);
    finish_frame(2);
    for (int i = 0; i < 100; i++) frame_bits[i] = 1'($urandom);
    send_frame(15, 100, 100, 1'b0, -1);
    finish_frame(0);
    send_frame(12, 90, 100, 1'b0, -1);
    finish_frame(0);

    // Reset during a frame discards it.
    clear_bits(); frame_bits[2] = 1'b1;
    send_frame(5, 31, 31, 1'b0, 10);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_syn", out_syndromes, '0);
    repeat (3) begin @(posedge clk); #1; end
    chk("midrst_no_out", out_valid, 1'b0);

    // Reset while a result is pending
    send_frame(5, 31, 31, 1'b0, -1);
    exp_pending = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("pendrst_valid", out_valid, 1'b0);
    chk("pendrst_flags", {out_nonzero, out_len_err, out_cfg_err}, 3'b000);

    clear_bits();
    send_frame(5, 31, 31, 1'b1, -1);
    chk("gap_zero_syn", out_syndromes, '0);
    finish_frame(0);

    // The same random frame is sent gapless and gapped. Both results must match.
    for (int i = 0; i < 63; i++) frame_bits[i] = 1'($urandom);
    send_frame(6, 63, 63, 1'b0, -1);
    gapless_syn = out_syndromes;
    finish_frame(0);
    send_frame(6, 63, 63, 1'b1, -1);
    chk("gap_vs_gapless", out_syndromes, gapless_syn);
    finish_frame(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bch_syndrome_calculator.md
Name: bch_syndrome_calculator

Overview:
- Serial BCH syndrome engine over GF(2^m). It computes S_j = r(alpha^j) for j = 1..2T over one received codeword r.
- m is selectable per frame at run time in the range 5..MAX_M_P. Each m uses its standard primitive polynomial: 0x25, 0x43, 0x83, 0x11D, 0x211, 0x409, 0x805, 0x1053, 0x201B, 0x402B, 0x8003 for m = 5..15.
- Sits between the channel bit stream and the BCH error locator stage of the decoder VIP/RTL.

Parameters:
- MAX_M_P, 15, largest supported field degree; legal range 5..15.
- T_P, 4, error-correcting capability; 2*T_P syndromes are produced.
- N_WIDTH_P, 16, width of the codeword length and beat counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_m  in  4  field degree; sampled on the first accepted beat of a frame
- cfg_n  in  N_WIDTH_P  codeword length in bits; sampled with cfg_m
- in_valid  in  1  input bit valid
- in_ready  out  1  input bit accepted when in_valid && in_ready
- in_data  in  1  received bit, highest-degree coefficient r_{n-1} first
- in_last  in  1  marks the final bit (r_0) of the codeword
- out_valid  out  1  result valid
- out_ready  in  1  result accepted when out_valid && out_ready
- out_syndromes  out  2*T_P*MAX_M_P  S_1 in bits [MAX_M_P-1:0], S_2 in the next MAX_M_P bits, and so on
- out_nonzero  out  1  at least one syndrome is nonzero, i.e. an error is detected
- out_len_err  out  1  the number of beats differs from the latched cfg_n
- out_cfg_err  out  1  the latched cfg_m is outside 5..MAX_M_P

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_syndromes=0, out_nonzero=0, out_len_err=0, out_cfg_err=0. FSM=IDLE, beat counter=0, all S_j accumulators=0.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - On a handshake, latch cfg_m and cfg_n and select the primitive polynomial.
  - Apply the first update using S_j=0, so S_j becomes in_data. Set counter=1.
  - Go to ACCUM, or to DONE if in_last is set on that same beat.
- ACCUM: on each handshake, update every j in parallel as S_j <= mul_alpha_pow(S_j, j) XOR in_data, and increment the counter.
- mul_alpha_pow(x, j) is j chained multiply-by-alpha stages. One stage is: shift left by 1; if bit m is set, XOR with the polynomial; mask to m bits.
- All update arithmetic is combinational within one cycle. Accumulator bits at position >= m are always 0.
- Throughput is 1 bit per cycle. Holes in in_valid are allowed and leave the accumulators unchanged.
- DONE is entered on the in_last handshake. The registered result appears the next cycle: out_valid=1, latency 1 cycle after the last beat.
  - out_nonzero = OR of all S_j.
  - out_len_err = (final count != cfg_n).
  - out_cfg_err = (latched m < 5 or m > MAX_M_P).
- If cfg_err is set: the frame is still consumed bit-for-bit, but the accumulators stay 0 and out_nonzero=0.
- DONE holds in_ready=0. Outputs stay stable until out_ready is seen high. On that handshake: out_valid=0, accumulators clear, go to IDLE with in_ready=1.
  - The next frame's first beat can be accepted the cycle after the output handshake.
- Counter saturates at 2^N_WIDTH_P-1 and then flags out_len_err at the end of the frame.
- The frame ends only on in_last; a missing in_last keeps the block accumulating.
- cfg_m and cfg_n changes during ACCUM or DONE are ignored.
- rst at any point, including mid-frame or while out_valid is pending: return to reset values on the next edge and discard the partial frame. No output is produced for it.

Test Plan:
- m=5, n=31, all 31 bits zero, T_P=3 -> out_valid 1 cycle after in_last; all S_j=0x00; out_nonzero=0; out_len_err=0.
- m=5, n=31, only r_1=1 (bit 30 of 31 sent, i.e. the second-to-last beat) -> S_1..S_6 = 0x02, 0x04, 0x08, 0x10, 0x05, 0x0A; out_nonzero=1.
- m=5, only r_0=1 (last beat) -> S_1..S_6 all 0x01.
- m=8, n=255, only r_1=1 -> S_8 = 0x1D (poly 0x11D), S_1=0x02. Then repeat with out_ready held low 10 cycles -> outputs stable, in_ready=0 throughout.
- m=5, cfg_n=31, in_last on beat 20 -> out_len_err=1. Then cfg_m=4 with 31 beats -> out_cfg_err=1, syndromes 0, out_nonzero=0.
- rst pulsed on beat 10 of an m=5 frame -> outputs return to reset values. A following clean all-zero frame yields all-zero syndromes, and random in_valid gaps give the same result as a gapless frame.
